// File: rtl/hier_chain_stage.sv
// Ready/valid pipeline stage with one main and one skid register, used as the leaf of a daisy chain.
// Each accepted beat gets its hop count bumped (saturating), this stage's ID stamped, and a hop-limit flag.
module hier_chain_stage #(
  parameter int DATA_W   = 16,
  parameter int STAGE_ID = 0,
  parameter int MAX_HOPS = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [3:0]        s_hops,
  input  logic              s_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_hops,
  output logic [3:0]        m_last_id,
  output logic              m_err,
  output logic [15:0]       acc_count
);

  localparam logic [3:0] STAGE_ID_L = 4'(STAGE_ID);
  localparam logic [3:0] MAX_HOPS_L = 4'(MAX_HOPS);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        hops;
    logic [3:0]        last_id;
    logic              err;
  } beat_t;

  state_t      state_q, state_d;
  beat_t       main_q, main_d;
  beat_t       skid_q, skid_d;
  beat_t       in_beat;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [15:0] acc_q, acc_d;
  logic        accept;
  logic        emit;

  assign accept = s_valid && s_ready_q;
  assign emit   = m_valid_q && m_ready;

  always_comb begin
    in_beat.data    = s_data;
    in_beat.hops    = (s_hops == 4'hF) ? 4'hF : s_hops + 4'd1;
    in_beat.last_id = STAGE_ID_L;
    in_beat.err     = s_err | (s_hops >= MAX_HOPS_L);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = ST_TWO;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // s_ready is low here, so upstream cannot be accepted; only drain skid.
        if (emit) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake outputs are registered from the next state so neither depends on m_ready combinationally.
    s_ready_d = (state_d != ST_TWO);
    m_valid_d = (state_d != ST_EMPTY);
    acc_d     = acc_q + 16'(accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      acc_q     <= acc_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q.data;
  assign m_hops    = main_q.hops;
  assign m_last_id = main_q.last_id;
  assign m_err     = main_q.err;
  assign acc_count = acc_q;

endmodule

// File: tb/tb_hier_chain_stage.sv
// Bench for hier_chain_stage: a standalone stage (ID 3, hop limit 4) and a 5-stage chain (IDs 0..4),
// both checked through expected-beat queues filled on accept and drained on emit.
module tb_hier_chain_stage;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standalone stage
  logic        u_s_valid, u_s_ready, u_s_err, u_m_valid, u_m_ready, u_m_err;
  logic [15:0] u_s_data, u_m_data, u_acc;
  logic [3:0]  u_s_hops, u_m_hops, u_m_last_id;

  hier_chain_stage #(.DATA_W(16), .STAGE_ID(3), .MAX_HOPS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(u_s_valid), .s_ready(u_s_ready), .s_data(u_s_data), .s_hops(u_s_hops), .s_err(u_s_err),
    .m_valid(u_m_valid), .m_ready(u_m_ready), .m_data(u_m_data), .m_hops(u_m_hops),
    .m_last_id(u_m_last_id), .m_err(u_m_err), .acc_count(u_acc)
  );

  // Five-stage chain: link index i is the input of stage i, link 5 is the tail
  logic        c_s_valid, c_s_err, c_m_ready;
  logic [15:0] c_s_data;
  logic [3:0]  c_s_hops;
  logic        lv [0:5];
  logic        lr [0:5];
  logic        le [0:5];
  logic [15:0] ld [0:5];
  logic [3:0]  lh [0:5];
  logic [3:0]  lid [1:5];
  logic [15:0] c_acc [0:4];

  assign lv[0] = c_s_valid;
  assign ld[0] = c_s_data;
  assign lh[0] = c_s_hops;
  assign le[0] = c_s_err;
  assign lr[5] = c_m_ready;

  for (genvar gi = 0; gi < 5; gi++) begin : g_chain
    hier_chain_stage #(.DATA_W(16), .STAGE_ID(gi), .MAX_HOPS(15)) u_stage (
      .clk(clk), .rst_n(rst_n),
      .s_valid(lv[gi]), .s_ready(lr[gi]), .s_data(ld[gi]), .s_hops(lh[gi]), .s_err(le[gi]),
      .m_valid(lv[gi+1]), .m_ready(lr[gi+1]), .m_data(ld[gi+1]), .m_hops(lh[gi+1]),
      .m_last_id(lid[gi+1]), .m_err(le[gi+1]), .acc_count(c_acc[gi])
    );
  end

  logic [24:0] u_q[$];
  logic [24:0] c_q[$];
  int          u_emits;
  int          c_emits;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outgoing beat for one stage, built from the incoming fields.
  function automatic logic [24:0] model(input logic [15:0] d, input logic [3:0] h, input logic e,
                                        input logic [3:0] id, input int max_hops);
    logic [3:0] nh;
    logic       ne;
    nh = (h == 4'd15) ? 4'd15 : h + 4'd1;
    ne = e || (int'(h) >= max_hops);
    return {d, nh, id, ne};
  endfunction

  // Scoreboard fill on accept, drain on emit, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_s_valid && u_s_ready)
        u_q.push_back(model(u_s_data, u_s_hops, u_s_err, 4'd3, 4));
      if (u_m_valid && u_m_ready) begin
        u_emits++;
        if (u_q.size() == 0) check("u_unexpected_beat", 64'd1, 64'd0);
        else check("u_beat", {39'd0, u_m_data, u_m_hops, u_m_last_id, u_m_err}, {39'd0, u_q.pop_front()});
      end
      if (c_s_valid && lr[0])
        c_q.push_back({c_s_data, 4'd5, 4'd4, 1'b0});
      if (lv[5] && lr[5]) begin
        c_emits++;
        if (c_q.size() == 0) check("c_unexpected_beat", 64'd1, 64'd0);
        else check("c_beat", {39'd0, ld[5], lh[5], lid[5], le[5]}, {39'd0, c_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    u_q.delete();
    c_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Wait until the standalone stage takes its current beat; returns stall cycles seen.
  task automatic u_wait_accept(output int waits);
    waits = 0;
    @(negedge clk);
    while (!u_s_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) check("u_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    u_s_valid = 1'b0;
  endtask

  task automatic u_send(input logic [15:0] d, input logic [3:0] h, input logic e, output int waits);
    u_s_valid = 1'b1;
    u_s_data  = d;
    u_s_hops  = h;
    u_s_err   = e;
    u_wait_accept(waits);
  endtask

  task automatic c_send(input logic [15:0] d);
    int waits;
    waits     = 0;
    c_s_valid = 1'b1;
    c_s_data  = d;
    @(negedge clk);
    while (!lr[0] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) check("c_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    c_s_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int which);
    int n;
    n = 0;
    while (((which == 0) ? u_q.size() : c_q.size()) != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'((which == 0) ? u_q.size() : c_q.size()), 64'd0);
  endtask

  int w;
  int stalls;
  int base;
  int c_done;
  logic [3:0] hop_in [0:3];
  logic       err_in [0:3];
  logic [3:0] hop_exp [0:3];
  logic       err_exp [0:3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; u_emits = 0; c_emits = 0;
    rst_n = 1'b0;
    u_s_valid = 1'b0; u_s_data = '0; u_s_hops = '0; u_s_err = 1'b0; u_m_ready = 1'b1;
    c_s_valid = 1'b0; c_s_data = '0; c_s_hops = '0; c_s_err = 1'b0; c_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_m_valid", 64'(u_m_valid), 64'd0);
    check("rst_s_ready", 64'(u_s_ready), 64'd1);
    check("rst_acc", 64'(u_acc), 64'd0);
    check("rst_m_fields", {39'd0, u_m_data, u_m_hops, u_m_last_id, u_m_err}, 64'd0);

    // Reset with two beats buffered
    u_m_ready = 1'b0;
    u_send(16'h0011, 4'd0, 1'b0, w);
    u_send(16'h0022, 4'd0, 1'b0, w);
    check("mid_two_buffered", {62'd0, u_m_valid, u_s_ready}, {62'd0, 1'b1, 1'b0});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(u_m_valid), 64'd0);
    check("mid_rst_s_ready", 64'(u_s_ready), 64'd1);
    check("mid_rst_acc", 64'(u_acc), 64'd0);
    u_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    u_m_ready = 1'b1;
    @(posedge clk);
    #1;

    // Single beat
    u_send(16'hA5A5, 4'd2, 1'b0, w);
    check("single_m_valid", 64'(u_m_valid), 64'd1);
    check("single_m_data", 64'(u_m_data), 64'hA5A5);
    check("single_m_hops", 64'(u_m_hops), 64'd3);
    check("single_last_id", 64'(u_m_last_id), 64'd3);
    check("single_m_err", 64'(u_m_err), 64'd0);
    check("single_acc", 64'(u_acc), 64'd1);

    // Hop limit and saturation with limit 4
    hop_in[0] = 4'd3;  err_in[0] = 1'b0; hop_exp[0] = 4'd4;  err_exp[0] = 1'b0;
    hop_in[1] = 4'd4;  err_in[1] = 1'b0; hop_exp[1] = 4'd5;  err_exp[1] = 1'b1;
    hop_in[2] = 4'd15; err_in[2] = 1'b0; hop_exp[2] = 4'd15; err_exp[2] = 1'b1;
    hop_in[3] = 4'd0;  err_in[3] = 1'b1; hop_exp[3] = 4'd1;  err_exp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_send(16'(16'h0100 + i), hop_in[i], err_in[i], w);
      check($sformatf("hop%0d_hops", i), 64'(u_m_hops), 64'(hop_exp[i]));
      check($sformatf("hop%0d_err", i), 64'(u_m_err), 64'(err_exp[i]));
    end
    drain("hop_drain", 0);

    // Streaming 100 beats back to back
    do_reset();
    base = u_emits;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      u_send(16'(i), 4'd0, 1'b0, w);
      stalls += w;
    end
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_acc", 64'(u_acc), 64'd100);
    @(posedge clk);
    #1;
    check("stream_one_per_cycle", 64'(u_emits - base), 64'd100);
    drain("stream_drain", 0);

    // Backpressure into the skid register
    do_reset();
    u_m_ready = 1'b0;
    u_send(16'd1, 4'd0, 1'b0, w);
    u_send(16'd2, 4'd0, 1'b0, w);
    check("bp_s_ready_low", 64'(u_s_ready), 64'd0);
    u_s_valid = 1'b1; u_s_data = 16'd3; u_s_hops = 4'd0; u_s_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_s_ready", 64'(u_s_ready), 64'd0);
    check("bp_held_acc", 64'(u_acc), 64'd2);
    check("bp_main_stable", {47'd0, u_m_valid, u_m_data}, {47'd0, 1'b1, 16'd1});
    u_m_ready = 1'b1;
    u_wait_accept(w);
    drain("bp_drain", 0);
    check("bp_acc", 64'(u_acc), 64'd3);
    check("bp_empty_after", 64'(u_m_valid), 64'd0);

    // Five-stage chain with random tail backpressure
    do_reset();
    base = c_emits;
    c_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) c_send(16'(i));
        c_done = 1;
      end
      begin
        while (c_done == 0) begin
          @(posedge clk);
          #1;
          c_m_ready = 1'($urandom_range(0, 1));
        end
        c_m_ready = 1'b1;
      end
    join
    drain("chain_drain", 1);
    check("chain_emits", 64'(c_emits - base), 64'd1000);
    for (int i = 0; i < 5; i++)
      check($sformatf("chain_acc%0d", i), 64'(c_acc[i]), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hier_chain_stage.md
# hier_chain_stage

- Registered ready/valid pipeline stage that forms the leaf level of the generated module hierarchy.
- Sibling instances are daisy-chained: instance N consumes what instance N-1 produces and feeds instance N+1.
- Each stage buffers one beat plus one skid entry, increments a saturating hop count, stamps its own ID, and flags hop-limit overruns.
- A free-running accept counter lets the bench confirm that traffic actually traversed every instance of the tree.

## Interface
Parameters:
- DATA_W, 16, payload width (1..64)
- STAGE_ID, 0, 4-bit identifier of this stage
- MAX_HOPS, 15, hop count at or above which an incoming beat is flagged (1..15)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- s_valid  in  1  upstream beat present
- s_ready  out  1  stage can accept; registered
- s_data  in  DATA_W  upstream payload
- s_hops  in  4  hop count carried by upstream beat
- s_err  in  1  error flag carried by upstream beat
- m_valid  out  1  downstream beat present
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  payload, passed unmodified
- m_hops  out  4  outgoing hop count
- m_last_id  out  4  STAGE_ID of the last stage that handled the beat
- m_err  out  1  outgoing error flag
- acc_count  out  16  number of beats accepted since reset

## Operation
- Accept: s_valid && s_ready. Emit: m_valid && m_ready.
- On accept, the captured beat is {data = s_data, hops = min(s_hops+1, 15), last_id = STAGE_ID, err = s_err | (s_hops >= MAX_HOPS)}.
  - Hop arithmetic is 4-bit saturating: 15 stays 15.
- Storage is a main register (drives m_*) plus one skid register. State machine:
  - EMPTY: m_valid=0, s_ready=1. On accept, load main and go to ONE.
  - ONE: m_valid=1, s_ready=1.
    - Accept with emit: load main, stay in ONE.
    - Accept without emit: load skid, go to TWO.
    - Emit without accept: go to EMPTY.
  - TWO: m_valid=1, s_ready=0.
    - On emit, main <= skid and go to ONE.
    - s_valid is ignored in TWO.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- m_* is stable while m_valid && !m_ready.
- acc_count increments by 1 on every accept and wraps from 0xFFFF to 0x0000.
- s_data contents never affect control.

## Timing
- Reset values (async assert, synchronous deassert handled upstream):
  - state EMPTY, m_valid=0, s_ready=1.
  - m_data=0, m_hops=0, m_last_id=0, m_err=0, acc_count=0.
  - The skid register is cleared.
- Latency: a beat accepted at edge k is presented on m_* after edge k (visible in cycle k+1). There is no combinational path from s_* to m_*.
- s_ready depends only on registered state. There is no combinational path from m_ready to s_ready.
- Throughput: 1 beat/cycle sustained while m_ready=1.
- Backpressure: after m_ready drops, at most one further beat is accepted (into skid). s_ready falls the cycle after that accept.
- Simultaneous accept and emit in ONE: the new beat replaces main in the same edge, with no bubble.
- Reset mid-transfer: all buffered beats are discarded immediately. m_valid goes low asynchronously on rst_n fall.
- The upstream protocol requires s_valid to be held until accept, with s_* stable. Violations are not detected.

## Test plan
- Reset check: assert rst_n=0 mid-stream with two beats buffered -> m_valid=0, s_ready=1, acc_count=0 in the same cycle.
- Single beat: with STAGE_ID=3, send s_data=0xA5A5, s_hops=2, s_err=0, m_ready=1 -> the following cycle shows m_valid=1, m_data=0xA5A5, m_hops=3, m_last_id=3, m_err=0, acc_count=1.
- Streaming: send 100 back-to-back beats with data 0..99 and m_ready=1 -> output 0..99 in order, one per cycle, s_ready constantly 1, acc_count=100.
- Backpressure/skid: stream beats 1,2,3 and hold m_ready=0 from the cycle beat 1 appears:
  - beats 1 (main) and 2 (skid) are accepted; s_ready=0 and beat 3 is held.
  - then release m_ready -> output 1,2,3 in order with no loss.
- Hop limit and saturation: with MAX_HOPS=4:
  - s_hops=3 -> m_hops=4, m_err=0.
  - s_hops=4 -> m_hops=5, m_err=1.
  - s_hops=15 -> m_hops=15, m_err=1.
  - s_err=1 with s_hops=0 -> m_err=1.
- Chain of 5 stages (IDs 0..4) with random m_ready at the tail: inject 1000 beats with hops=0 -> all exit in order with m_hops=5, m_last_id=4, m_err=0, and each acc_count=1000.
